// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential double-dabble BCD converter.
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // Digits needed to hold any w-bit value: ceil(w * log10(2)), fixed-point.
  function automatic int nint_f(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

  // Leading-zero mask after reset: every digit blank except the ones digit.
  function automatic logic [63:0] blank_rst_f(input int ndig);
    return ((64'd1 << ndig) - 64'd1) & ~64'd1;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// Single-digit shift-and-add-3 correction applied before each shift.
module bcd_dabble_step
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_conv_seq.sv
// Sequential binary-to-BCD converter: one double-dabble step per cycle with
// start/busy/done handshake, leading-zero blank mask and overflow flag.
module bcd_conv_seq
  import bcd_pkg::*;
#(
  parameter int W    = 32,
  parameter int NDIG = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W-1:0]        value,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   digits,
  output logic [NDIG-1:0]     blank,
  output logic                overflow
);

  localparam int NINT = nint_f(W);
  localparam int CW   = $clog2(W + 1);
  localparam logic [NDIG-1:0] BLANK_RST = NDIG'(blank_rst_f(NDIG));

  state_t              state_reg, state_next;
  logic [CW-1:0]       count_reg, count_next;
  logic [W-1:0]        operand_reg, operand_next;
  logic [4*NINT-1:0]   scratch_reg, scratch_next;
  logic [4*NDIG-1:0]   digits_reg, digits_next;
  logic [NDIG-1:0]     blank_reg, blank_next;
  logic                overflow_reg, overflow_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;

  logic [4*NINT-1:0]   corr;
  logic [4*NINT-1:0]   shifted;
  logic [NDIG-1:0]     blank_calc;
  logic                ovf_calc;

  genvar gi;
  generate
    for (gi = 0; gi < NINT; gi++) begin : g_step
      bcd_dabble_step u_step (
        .din  (scratch_reg[4*gi +: 4]),
        .dout (corr[4*gi +: 4])
      );
    end
  endgenerate

  assign shifted = {corr[4*NINT-2:0], operand_reg[W-1]};

  // Blank mask is derived from the value being committed, so it lands with it.
  assign blank_calc[0] = 1'b0;
  generate
    for (gi = 1; gi < NDIG; gi++) begin : g_blank
      assign blank_calc[gi] = ~|shifted[4*NDIG-1:4*gi];
    end
  endgenerate

  // The bit shifted out of the scratch top is also a (never expected) overflow.
  generate
    if (NINT > NDIG) begin : g_ovf
      assign ovf_calc = corr[4*NINT-1] | (|shifted[4*NINT-1:4*NDIG]);
    end else begin : g_noovf
      assign ovf_calc = corr[4*NINT-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      operand_reg  <= '0;
      scratch_reg  <= '0;
      digits_reg   <= '0;
      blank_reg    <= BLANK_RST;
      overflow_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      operand_reg  <= operand_next;
      scratch_reg  <= scratch_next;
      digits_reg   <= digits_next;
      blank_reg    <= blank_next;
      overflow_reg <= overflow_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    operand_next  = operand_reg;
    scratch_next  = scratch_reg;
    digits_next   = digits_reg;
    blank_next    = blank_reg;
    overflow_next = overflow_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          operand_next = value;
          scratch_next = '0;
          count_next   = CW'(W);
          busy_next    = 1'b1;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_next = shifted;
        operand_next = operand_reg << 1;
        count_next   = count_reg - CW'(1);
        if (count_reg == CW'(1)) begin
          digits_next   = shifted[4*NDIG-1:0];
          blank_next    = blank_calc;
          overflow_next = ovf_calc;
          done_next     = 1'b1;
          busy_next     = 1'b0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign digits   = digits_reg;
  assign blank    = blank_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Scoreboard bench for bcd_conv_seq: expected results are queued at accept
// time from a divide/modulo reference and popped on each done pulse.
module tb_bcd_conv_seq;

  localparam int W    = 32;
  localparam int NDIG = 8;

  logic              clk   = 1'b0;
  logic              rst   = 1'b0;
  logic              start = 1'b0;
  logic [W-1:0]      value = '0;
  logic              busy;
  logic              done;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   blank;
  logic              overflow;

  typedef struct packed {
    logic [31:0] val;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  exp_t hold;
  int   checks = 0;
  int   errors = 0;
  int   cnt    = 0;
  logic e_busy = 1'b0;
  logic e_done = 1'b0;

  bcd_conv_seq #(.W(W), .NDIG(NDIG)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .digits   (digits),
    .blank    (blank),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] v);
    exp_t r;
    longint unsigned x;
    r = '0;
    r.val = v;
    x = longint'(v);
    for (int i = 0; i < NDIG; i++) begin
      r.digits[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    r.ovf = (x != 0);
    for (int i = 1; i < NDIG; i++)
      r.blank[i] = ((r.digits >> (4*i)) == 32'd0);
    return r;
  endfunction

  // Inputs change just after posedge, so the negedge sees what the next edge samples.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      cnt    = 0;
      e_busy = 1'b0;
      e_done = 1'b0;
      hold   = '{val: 32'd0, digits: 32'd0, blank: 8'hFE, ovf: 1'b0};
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_digits", digits, 0);
      check_eq("rst_blank", blank, 8'hFE);
      check_eq("rst_ovf", overflow, 0);
    end else begin
      check_eq("busy", busy, e_busy);
      check_eq("done", done, e_done);
      if (done) begin
        check_eq("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          hold = q.pop_front();
          $display("conv value=%0d digits=%h blank=%h ovf=%0d exp_digits=%h exp_blank=%h exp_ovf=%0d",
                   hold.val, digits, blank, overflow, hold.digits, hold.blank, hold.ovf);
        end
      end
      check_eq("digits", digits, hold.digits);
      check_eq("blank", blank, hold.blank);
      check_eq("ovf", overflow, hold.ovf);
      e_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) e_done = 1'b1;
      end else if (start) begin
        q.push_back(model(value));
        cnt = W;
      end
      e_busy = (cnt > 0);
    end
  end

  task automatic convert(input logic [31:0] v);
    int n;
    @(posedge clk); #2;
    start = 1'b1;
    value = v;
    @(posedge clk); #2;
    start = 1'b0;
    value = $urandom;
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("done_timeout", n < 60, 1);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    convert(32'd12345678);
    convert(32'd907);
    convert(32'd0);
    convert(32'hFFFFFFFF);
    convert(32'd99999999);
    convert(32'd100000000);

    // start held high with a changing operand: one accept every W+1 cycles
    @(posedge clk); #2;
    start = 1'b1;
    repeat (4 * (W + 1) + 3) begin
      value = $urandom;
      @(posedge clk); #2;
    end
    start = 1'b0;
    repeat (W + 5) @(posedge clk);
    #2;

    // abort a conversion partway through
    start = 1'b1;
    value = 32'd55555555;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (W + 5) @(posedge clk);
    #2;
    convert(32'd42);

    repeat (3) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
